// File: rtl/pwm_rx_pkg.sv
// Shared types, drive-state encodings and default parameters for the multi-channel PWM decoder.
// Pure declarations; no latency or flow control.
package pwm_rx_pkg;

    typedef enum logic [1:0] {
        ST_BRAKE = 2'b00,
        ST_SHORT = 2'b01,
        ST_OPEN  = 2'b10,
        ST_DRIVE = 2'b11
    } drive_e;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        MEASURE   = 2'd1,
        SATURATED = 2'd2
    } meter_fsm_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 10;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_TH0         = 307;
    localparam int DEF_TH1         = 409;
    localparam int DEF_TH2         = 512;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_GLITCH_LEN  = 3;

    function automatic drive_e classify(input int w, input int t0, input int t1, input int t2);
        if (w <= t0)      return ST_BRAKE;
        else if (w <= t1) return ST_SHORT;
        else if (w <= t2) return ST_OPEN;
        else              return ST_DRIVE;
    endfunction

endpackage

// File: rtl/pwm_width_meter.sv
// One PWM channel: synchronizer, optional glitch filter (PWM_GLITCH_FILTER_EN), width FSM and classifier.
// Result registered SYNC_STAGES (+GLITCH_LEN when filtered) edges after the line falls; no backpressure.
module pwm_width_meter
    import pwm_rx_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int TH0         = DEF_TH0,
    parameter int TH1         = DEF_TH1,
    parameter int TH2         = DEF_TH2,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GLITCH_LEN  = DEF_GLITCH_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_i,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] width_o,
    output logic             valid_o,
    output logic             timeout_o
);

    localparam int LOW_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    if (!(TH0 < TH1 && TH1 < TH2 && TH2 < (1 << CNT_W) - 1)) begin : g_bad_thresholds
        $error("pwm_width_meter: thresholds must satisfy TH0 < TH1 < TH2 < 2^CNT_W-1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pwm_width_meter: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pwm_width_meter: TIMEOUT must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw_s;
    logic                   s;
    logic                   s_d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
    end
    assign raw_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_LEN + 1);
    logic          filt_q, filt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;

    // Output follows the raw line only after GLITCH_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        gcnt_d = '0;
        if (raw_s != filt_q) begin
            if (gcnt_q == GW'(GLITCH_LEN - 1)) filt_d = raw_s;
            else                               gcnt_d = gcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            gcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            gcnt_q <= gcnt_d;
        end
    end
    assign s = filt_q;
`else
    assign s = raw_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) s_d_q <= 1'b0;
        else       s_d_q <= s;
    end

    logic rise, fall;
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    meter_fsm_e       fsm_q, fsm_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [LOW_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    drive_e           drv_q, drv_d;
    logic             valid_q, valid_d;
    logic             flag_q, flag_d;
    logic             latch;
    logic [CNT_W-1:0] latch_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fsm_q <= IDLE_LOW;
        else       fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE_LOW:  if (rise) fsm_d = MEASURE;
            MEASURE: begin
                if (fall)                        fsm_d = IDLE_LOW;
                else if (s && wcnt_q == MAX_CNT) fsm_d = SATURATED;
            end
            SATURATED: if (fall) fsm_d = IDLE_LOW;
            default:   fsm_d = IDLE_LOW;
        endcase
    end

    // The low counter starts at 1 on the fall so it counts every synchronized-low cycle.
    always_comb begin
        wcnt_d  = wcnt_q;
        lcnt_d  = lcnt_q;
        flag_d  = flag_q;
        latch   = 1'b0;
        latch_w = '0;
        case (fsm_q)
            IDLE_LOW: begin
                if (rise) begin
                    wcnt_d = CNT_W'(1);
                    lcnt_d = '0;
                    flag_d = 1'b0;
                end else if (!s && lcnt_q != LOW_W'(TIMEOUT)) begin
                    lcnt_d = lcnt_q + 1'b1;
                    if (lcnt_q == LOW_W'(TIMEOUT - 1)) begin
                        latch  = 1'b1;
                        flag_d = 1'b1;
                    end
                end
            end
            MEASURE: begin
                if (fall) begin
                    latch   = 1'b1;
                    latch_w = wcnt_q;
                    lcnt_d  = LOW_W'(1);
                end else if (s) begin
                    if (wcnt_q == MAX_CNT) begin
                        latch   = 1'b1;
                        latch_w = MAX_CNT;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            SATURATED: begin
                if (fall) lcnt_d = LOW_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d = latch;
        width_d = latch ? latch_w : width_q;
        drv_d   = latch ? classify(int'(latch_w), TH0, TH1, TH2) : drv_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q  <= '0;
            lcnt_q  <= '0;
            width_q <= '0;
            drv_q   <= ST_BRAKE;
            valid_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            lcnt_q  <= lcnt_d;
            width_q <= width_d;
            drv_q   <= drv_d;
            valid_q <= valid_d;
            flag_q  <= flag_d;
        end
    end

    assign state_o   = drv_q;
    assign width_o   = width_q;
    assign valid_o   = valid_q;
    assign timeout_o = flag_q;

endmodule

// File: rtl/pwm_state_decoder_mc.sv
// NUM_CH independent PWM width meters packed onto flat buses; PWM_GLITCH_FILTER_EN adds an input filter.
// Per-channel result SYNC_STAGES (+GLITCH_LEN) edges after the falling edge; no backpressure.
module pwm_state_decoder_mc
    import pwm_rx_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int TH0         = DEF_TH0,
    parameter int TH1         = DEF_TH1,
    parameter int TH2         = DEF_TH2,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GLITCH_LEN  = DEF_GLITCH_LEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       pwm_in,
    output logic [2*NUM_CH-1:0]     state_out,
    output logic [CNT_W*NUM_CH-1:0] width_out,
    output logic [NUM_CH-1:0]       valid_pulse,
    output logic [NUM_CH-1:0]       timeout_flag
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_width_meter #(
            .CNT_W       (CNT_W),
            .TIMEOUT     (TIMEOUT),
            .TH0         (TH0),
            .TH1         (TH1),
            .TH2         (TH2),
            .SYNC_STAGES (SYNC_STAGES),
            .GLITCH_LEN  (GLITCH_LEN)
        ) u_meter (
            .clk       (clk),
            .reset     (reset),
            .pwm_i     (pwm_in[i]),
            .state_o   (state_out[2*i +: 2]),
            .width_o   (width_out[CNT_W*i +: CNT_W]),
            .valid_o   (valid_pulse[i]),
            .timeout_o (timeout_flag[i])
        );
    end

endmodule

// File: tb/tb_pwm_state_decoder_mc.sv
// Self-checking bench for pwm_state_decoder_mc: per-channel expected-result queues, popped on valid_pulse.
// Glitch-filter scenario is compiled only when PWM_GLITCH_FILTER_EN is defined.
module tb_pwm_state_decoder_mc;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 10;
    localparam int TIMEOUT    = 1024;
    localparam int GLITCH_LEN = 3;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int LAT = 2 + GLITCH_LEN;
`else
    localparam int LAT = 2;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       pwm_in = '0;
    logic [2*NUM_CH-1:0]     state_out;
    logic [CNT_W*NUM_CH-1:0] width_out;
    logic [NUM_CH-1:0]       valid_pulse;
    logic [NUM_CH-1:0]       timeout_flag;

    pwm_state_decoder_mc #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TH0(307), .TH1(409), .TH2(512),
        .SYNC_STAGES(2), .GLITCH_LEN(GLITCH_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .state_out    (state_out),
        .width_out    (width_out),
        .valid_pulse  (valid_pulse),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] w;
        logic [1:0]       st;
        logic             fl;
    } exp_t;

    exp_t exp_q [NUM_CH][$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_vld_cyc [NUM_CH];
    int   vcount [NUM_CH];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] exp_state(input int w);
        if (w <= 307)      return 2'b00;
        else if (w <= 409) return 2'b01;
        else if (w <= 512) return 2'b10;
        else               return 2'b11;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (valid_pulse[ch]) begin
                    n_cmp++;
                    last_vld_cyc[ch] = cyc;
                    vcount[ch]++;
                    if (exp_q[ch].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_valid ch%0d: got width=%0d state=%b flag=%b, expected no valid",
                                 ch, width_out[ch*CNT_W +: CNT_W], state_out[ch*2 +: 2], timeout_flag[ch]);
                    end else begin
                        mon_e = exp_q[ch].pop_front();
                        if (width_out[ch*CNT_W +: CNT_W] !== mon_e.w || state_out[ch*2 +: 2] !== mon_e.st ||
                            timeout_flag[ch] !== mon_e.fl) begin
                            n_fail++;
                            $display("FAIL result ch%0d: got width=%0d state=%b flag=%b, expected width=%0d state=%b flag=%b",
                                     ch, width_out[ch*CNT_W +: CNT_W], state_out[ch*2 +: 2], timeout_flag[ch],
                                     mon_e.w, mon_e.st, mon_e.fl);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int w, input logic [1:0] st, input logic fl);
        exp_t e;
        e.w  = CNT_W'(w);
        e.st = st;
        e.fl = fl;
        exp_q[ch].push_back(e);
    endtask

    task automatic pulse(input int ch, input int n);
        pwm_in[ch] = 1'b1;
        tick(n);
        pwm_in[ch] = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output int pending);
        pending = 0;
        for (int i = 0; i < budget; i++) begin
            pending = 0;
            for (int ch = 0; ch < NUM_CH; ch++) pending += exp_q[ch].size();
            if (pending == 0) break;
            tick(1);
        end
        pending = 0;
        for (int ch = 0; ch < NUM_CH; ch++) pending += exp_q[ch].size();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        pwm_in = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            exp_q[ch].delete();
            vcount[ch] = 0;
            last_vld_cyc[ch] = -1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (state_out !== '0) begin n_fail++; $display("FAIL reset_state: got %b, expected 0", state_out); end
        n_cmp++;
        if (width_out !== '0) begin n_fail++; $display("FAIL reset_width: got %h, expected 0", width_out); end
        n_cmp++;
        if (valid_pulse !== '0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid_pulse); end
        n_cmp++;
        if (timeout_flag !== '0) begin n_fail++; $display("FAIL reset_timeout: got %b, expected 0", timeout_flag); end
    endtask

    task automatic test_basic_width();
        int c0, pend;
        do_reset();
        tick(5);
        push(0, 200, 2'b00, 1'b0);
        pulse(0, 200);
        c0 = cyc;
        wait_drain(100, pend);
        tick(5);
        n_cmp++;
        if (pend != 0) begin n_fail++; $display("FAIL basic_drain: %0d results pending, expected 0", pend); end
        n_cmp++;
        if (last_vld_cyc[0] != c0 + 1 + LAT) begin
            n_fail++;
            $display("FAIL basic_latency: valid at cycle %0d, expected %0d", last_vld_cyc[0], c0 + 1 + LAT);
        end
        n_cmp++;
        if (vcount[0] != 1) begin n_fail++; $display("FAIL basic_single_valid: %0d valids, expected 1", vcount[0]); end
        n_cmp++;
        if (width_out[CNT_W*NUM_CH-1:CNT_W] !== '0 || state_out[2*NUM_CH-1:2] !== '0) begin
            n_fail++;
            $display("FAIL basic_others: width=%h state=%b, expected 0", width_out[CNT_W*NUM_CH-1:CNT_W],
                     state_out[2*NUM_CH-1:2]);
        end
    endtask

    task automatic test_thresholds();
        int widths [6] = '{307, 308, 409, 410, 512, 513};
        int pend;
        do_reset();
        push(0, 0, 2'b00, 1'b1);
        push(2, 0, 2'b00, 1'b1);
        push(3, 0, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            push(1, widths[i], exp_state(widths[i]), 1'b0);
            pulse(1, widths[i]);
            tick(20);
        end
        wait_drain(200, pend);
        n_cmp++;
        if (pend != 0) begin n_fail++; $display("FAIL thresh_drain: %0d results pending, expected 0", pend); end
        n_cmp++;
        if (timeout_flag !== 4'b1101) begin
            n_fail++;
            $display("FAIL thresh_idle_timeouts: got %b, expected 1101", timeout_flag);
        end
    endtask

    task automatic test_saturation();
        int pend;
        do_reset();
        push(0, 0, 2'b00, 1'b1);
        push(1, 0, 2'b00, 1'b1);
        push(3, 0, 2'b00, 1'b1);
        push(2, 1023, 2'b11, 1'b0);
        pulse(2, 1100);
        wait_drain(200, pend);
        tick(20);
        n_cmp++;
        if (pend != 0) begin n_fail++; $display("FAIL sat_drain: %0d results pending, expected 0", pend); end
        n_cmp++;
        if (vcount[2] != 1) begin n_fail++; $display("FAIL sat_single_valid: %0d valids, expected 1", vcount[2]); end
        n_cmp++;
        if (width_out[2*CNT_W +: CNT_W] !== 10'd1023) begin
            n_fail++;
            $display("FAIL sat_width_hold: got %0d, expected 1023", width_out[2*CNT_W +: CNT_W]);
        end
    endtask

    task automatic test_timeout();
        int pend;
        do_reset();
        push(0, 0, 2'b00, 1'b1);
        push(1, 0, 2'b00, 1'b1);
        push(2, 0, 2'b00, 1'b1);
        push(3, 450, 2'b10, 1'b0);
        push(3, 100, 2'b00, 1'b0);
        push(3, 0, 2'b00, 1'b1);
        pulse(3, 450);
        tick(TIMEOUT - 1);
        pulse(3, 100);
        tick(TIMEOUT);
        tick(5);
        wait_drain(50, pend);
        n_cmp++;
        if (pend != 0) begin n_fail++; $display("FAIL timeout_drain: %0d results pending, expected 0", pend); end
        n_cmp++;
        if (vcount[3] != 3) begin n_fail++; $display("FAIL timeout_valid_count: %0d valids, expected 3", vcount[3]); end
        n_cmp++;
        if (timeout_flag !== 4'b1111) begin n_fail++; $display("FAIL timeout_flags: got %b, expected 1111", timeout_flag); end
        tick(100);
        n_cmp++;
        if (vcount[3] != 3) begin n_fail++; $display("FAIL timeout_no_repeat: %0d valids, expected 3", vcount[3]); end
        pwm_in[3] = 1'b1;
        tick(LAT + 2);
        n_cmp++;
        if (timeout_flag !== 4'b0111) begin n_fail++; $display("FAIL timeout_clear: got %b, expected 0111", timeout_flag); end
    endtask

    task automatic test_async_reset();
        int pend;
        do_reset();
        push(1, 100, 2'b00, 1'b0);
        pulse(1, 100);
        wait_drain(50, pend);
        n_cmp++;
        if (pend != 0) begin n_fail++; $display("FAIL areset_pre_drain: %0d results pending, expected 0", pend); end
        pwm_in[0] = 1'b1;
        tick(302);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (width_out !== '0 || state_out !== '0 || valid_pulse !== '0 || timeout_flag !== '0) begin
            n_fail++;
            $display("FAIL areset_outputs: width=%h state=%b valid=%b flag=%b, expected all 0",
                     width_out, state_out, valid_pulse, timeout_flag);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) vcount[ch] = 0;
        push(0, 100, 2'b00, 1'b0);
        tick(100);
        pwm_in[0] = 1'b0;
        wait_drain(50, pend);
        n_cmp++;
        if (pend != 0) begin n_fail++; $display("FAIL areset_partial_drain: %0d results pending, expected 0", pend); end
        n_cmp++;
        if (width_out[CNT_W-1:0] !== 10'd100) begin
            n_fail++;
            $display("FAIL areset_partial_width: got %0d, expected 100", width_out[CNT_W-1:0]);
        end
    endtask

`ifdef PWM_GLITCH_FILTER_EN
    task automatic test_glitch_filter();
        int pend;
        do_reset();
        pulse(0, 2);
        tick(20);
        n_cmp++;
        if (vcount[0] != 0) begin n_fail++; $display("FAIL glitch_ignored: %0d valids, expected 0", vcount[0]); end
        push(0, 200, 2'b00, 1'b0);
        pulse(0, 200);
        wait_drain(50, pend);
        n_cmp++;
        if (pend != 0) begin n_fail++; $display("FAIL glitch_pulse_drain: %0d results pending, expected 0", pend); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_width();
        test_thresholds();
        test_saturation();
        test_timeout();
        test_async_reset();
`ifdef PWM_GLITCH_FILTER_EN
        test_glitch_filter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
